// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   - default widths, reset PC and FIFO depth
//   - NOP encoding shown to decode when the fetch buffer is empty
//   - fetch FSM state encoding
//   - helper that flags a fetch target that is not word aligned
package ifu_pkg;

    localparam int          IFU_XLEN       = 64;
    localparam int          IFU_INST_LEN   = 32;
    localparam logic [63:0] IFU_RESET_PC   = 64'h8000_0000;
    localparam int          IFU_FIFO_DEPTH = 2;
    localparam logic [31:0] IFU_NOP        = 32'h0000_0013;   // addi x0, x0, 0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // one cycle after reset only
        ST_REQ  = 2'd1,   // presenting (or waiting to present) a request
        ST_WAIT = 2'd2    // one request outstanding, waiting for its response
    } ifu_state_e;

    function automatic logic addr_misaligned(input logic [1:0] lsbs);
        return (lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: small synchronous show-ahead FIFO holding fetched {pc, instr} pairs.
//   clk, rst_n   clock / asynchronous active-low reset
//   push/push_data   write one entry (ignored when full or flushing)
//   pop              remove the head entry (ignored when empty or flushing)
//   flush            discard all entries; wins over push and pop
//   head_data        current head entry (stale contents when empty)
//   full, empty, count   occupancy, count is clog2(DEPTH)+1 bits wide
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign head_data = entries[rd_ptr_q];

    // One register per entry; only the slot under the write pointer loads.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q, entry_d;

        always_comb begin
            entry_d = entry_q;
            if (do_push && (wr_ptr_q == PW'(gi))) begin
                entry_d = push_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign entries[gi] = entry_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, producer side of the decode interface.
//   clk, rst_n                       clock / asynchronous active-low reset
//   redirect_i, redirect_pc_i        taken branch/jump from execute: flush, refetch
//   imem_req_valid_o/ready_i/addr_o  word fetch request channel (valid/ready)
//   imem_rsp_valid_i/data_i          one in-order response per accepted request
//   instr_valid_o/ready_i            decode handshake
//   instr_o, pc_o                    head of the fetch buffer (NOP / 0 when empty)
//   misalign_o                       only with IFU_MISALIGN_CHK_EN defined
// Build option IFU_MISALIGN_CHK_EN: when defined, a redirect to a non word
// aligned target raises misalign_o and stalls fetching until a redirect to an
// aligned target; when undefined the low two target bits are ignored.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int               XLEN       = IFU_XLEN,
    parameter int               INST_LEN   = IFU_INST_LEN,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(IFU_RESET_PC),
    parameter int               FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                imem_req_valid_o,
    input  logic                imem_req_ready_i,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_rsp_valid_i,
    input  logic [INST_LEN-1:0] imem_rsp_data_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [INST_LEN-1:0] instr_o,
    output logic [XLEN-1:0]     pc_o
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                misalign_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = XLEN + INST_LEN;

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic [XLEN-1:0]   redirect_target;
    logic              fetch_stall;
    logic              outstanding;
    logic              has_room;
    logic              req_valid;
    logic              fifo_push;
    logic              fifo_pop;
    logic [EW-1:0]     fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              unused_sig;

    // ------------------------------------------------------------------
    // Optional misalignment check
    // ------------------------------------------------------------------
`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    assign redirect_target = redirect_pc_i;
    assign fetch_stall     = misalign_q;
    assign misalign_o      = misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_i) begin
            misalign_d = addr_misaligned(redirect_pc_i[1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign fetch_stall     = 1'b0;
`endif

    assign unused_sig = ^{redirect_pc_i[1:0], fifo_full};

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    // Only one request may be in flight, and it only exists while waiting.
    assign outstanding = (state_q == ST_WAIT);
    // Reserve a buffer slot for every request so a response can always land.
    assign has_room = ({1'b0, fifo_count} + {{CW{1'b0}}, outstanding})
                      < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        req_valid  = 1'b0;
        fifo_push  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req_valid = !redirect_i && !fetch_stall && has_room;
                if (req_valid && imem_req_ready_i) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid_i) begin
                    // A response that coincides with a redirect is wrong-path
                    // and simply vanishes; a pending drop is consumed here.
                    fifo_push = !drop_q && !redirect_i;
                    drop_d    = 1'b0;
                    state_d   = ST_REQ;
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect_i) begin
            fetch_pc_d = redirect_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
        end
    end

    // fetch_pc only moves on a handshake or a redirect (which lowers valid),
    // so the address is stable while a request is stalled.
    assign imem_req_valid_o = req_valid;
    assign imem_addr_o      = fetch_pc_q;

    // ------------------------------------------------------------------
    // Fetch buffer and decode side
    // ------------------------------------------------------------------
    assign instr_valid_o = !fifo_empty && !redirect_i;
    assign fifo_pop      = instr_valid_o && instr_ready_i;

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({req_pc_q, imem_rsp_data_i}),
        .pop       (fifo_pop),
        .flush     (redirect_i),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_o = fifo_empty ? INST_LEN'(IFU_NOP) : fifo_head[INST_LEN-1:0];
    assign pc_o    = fifo_empty ? '0 : fifo_head[EW-1:INST_LEN];

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit; the producer side of the decode interface. Holds the PC, issues word fetches to instruction memory over a valid/ready request channel, and collects responses. Buffers up to 2 {pc, instr} pairs and hands them to decode via valid/ready. Accepts branch/jump redirects from execute and discards any wrong-path fetches.

Parameters:
XLEN, 64, PC/address width
INST_LEN, 32, instruction width
RESET_PC, 64'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, fetch buffer entries (power of 2, >=2)

Ports:
- Interface (already decided): one clock `clk`; reset `rst_n`, asynchronous, active-low.
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- redirect_i  input  1  taken branch/jal/jalr; flush and refetch
- redirect_pc_i  input  XLEN  new fetch address
- imem_req_valid_o  output  1  fetch request valid
- imem_req_ready_i  input  1  memory accepts request
- imem_addr_o  output  XLEN  fetch address
- imem_rsp_valid_i  input  1  response data valid (exactly one per accepted request, in order, >=1 cycle later)
- imem_rsp_data_i  input  INST_LEN  fetched word
- instr_valid_o  output  1  instr_o/pc_o valid to decode
- instr_ready_i  input  1  decode consumes
- instr_o  output  INST_LEN  instruction to decode
- pc_o  output  XLEN  PC of instr_o

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; imem_req_valid_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0.
- FSM states IDLE, REQ, WAIT.
  - IDLE: only entered by reset; unconditionally goes to REQ next cycle.
  - REQ: imem_req_valid_o = !redirect_i && (count + outstanding < FIFO_DEPTH). Handshake (valid&&ready): latch req_pc=fetch_pc, fetch_pc+=4, go to WAIT.
  - WAIT: on imem_rsp_valid_i: if drop=0, push {req_pc, data} into the FIFO; if drop=1, discard and clear drop. Either way go to REQ.
- At most one outstanding request.
- imem_addr_o = fetch_pc; it is held stable while valid && !ready.
- Decode side:
  - instr_valid_o = !fifo_empty && !redirect_i.
  - instr_o/pc_o show the FIFO head; instr_o = NOP when empty.
  - Pop on instr_valid_o && instr_ready_i.
  - Latency: response cycle N puts the entry at the head at N+1.
- Redirect (single-cycle pulse, highest priority):
  - Next edge: FIFO cleared, fetch_pc=redirect_pc_i.
  - In REQ: no request is issued in the redirect cycle (gated); stay in REQ.
  - In WAIT without a response in the same cycle: set drop=1.
  - In WAIT with a response in the same cycle: discard it, drop stays 0, go to REQ.
  - A pop in the redirect cycle is suppressed (valid masked).
- Push and pop in the same cycle on a full FIFO cannot occur: the request gating guarantees space. Push and pop together on a non-full FIFO leave count unchanged.
- Pointer wrap is modulo FIFO_DEPTH; count is width clog2(FIFO_DEPTH)+1.
- Back-to-back redirects: the last one wins; drop stays set until the single outstanding response returns.
- fetch_pc wraps modulo 2^XLEN.

Optional Feature:
IFU_MISALIGN_CHK_EN.
- Defined: adds output misalign_o (1 bit, reset 0). Set on a redirect with redirect_pc_i[1:0]!=0; fetching stalls in REQ until the next redirect with an aligned target, which clears misalign_o.
- Undefined: no port is added; redirect_pc_i[1:0] is forced to 0.

Decomposition:
- Shared defines header: XLEN, inst_len, RESET_PC, NOP encoding (32'h13), ifu FSM state encodings.
- Sub-module ifu_fifo: parameterised depth/width synchronous FIFO with push, pop, flush, full, empty, count. It uses the same clk and rst_n.

Test Plan:
- Reset, then imem ready and response latency 1, decode always ready -> requests to 8000_0000, 8000_0004, 8000_0008; pc_o/instr_o follow in order, the first valid 3 cycles after reset release.
- imem_req_ready_i low for 5 cycles -> imem_addr_o held at 8000_0000, imem_req_valid_o stays 1, no FIFO push.
- instr_ready_i low -> FIFO fills to 2 entries (8000_0000, 8000_0004), then no further request; instr_o stays at head 8000_0000.
- Redirect to 8000_0100 while WAIT, response 2 cycles later -> that response is dropped, next request is 8000_0100, decode next sees pc_o=8000_0100.
- Redirect in the same cycle as a response -> response discarded, instr_valid_o low that cycle, next fetch 8000_0100.
- With IFU_MISALIGN_CHK_EN defined: redirect to 8000_0102 -> misalign_o=1, no requests; redirect to 8000_0200 -> misalign_o=0, fetch resumes at 8000_0200.
